// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and request type for the regfile write arbiter
package regfile_pkg;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int ZERO_REG = 31;
  localparam int CNT_W = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/wr_slot.sv
// wr_slot: one-entry writeback holding slot with age flag
module wr_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  logic    drain,
  input  logic    set_older,
  input  wr_req_t d,
  output logic    valid,
  output logic    older,
  output wr_req_t q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      older <= 1'b0;
      q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      older <= 1'b0;
      q <= d;
    end else if (drain) begin
      valid <= 1'b0;
      older <= 1'b0;
    end else if (set_older) begin
      older <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: oldest-first arbitration of two writeback slots onto one regfile port
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic [31:0]       pending,
  output logic              busy,
  output logic [CNT_W-1:0]  commit_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);
  logic v0, v1, o0, o1, g0, g1, ld0, ld1, tie, rr_ptr;
  wr_req_t s0, s1;
  // a slot becomes older when the other slot is refilled while it stays put
  wr_slot u_slot0 (
    .clk(clk), .reset(reset), .load(ld0), .drain(g0), .set_older(v0 && !g0 && ld1),
    .d('{addr: req0_addr, data: req0_data}), .valid(v0), .older(o0), .q(s0)
  );
  wr_slot u_slot1 (
    .clk(clk), .reset(reset), .load(ld1), .drain(g1), .set_older(v1 && !g1 && ld0),
    .d('{addr: req1_addr, data: req1_data}), .valid(v1), .older(o1), .q(s1)
  );
  always_comb begin
    tie = v0 && v1 && !o0 && !o1;
    g0 = v0 && (!v1 || o0 || (!o1 && rr_ptr));
    g1 = v1 && !g0;
    req0_ready = !v0 || g0;
    req1_ready = !v1 || g1;
    ld0 = req0_valid && req0_ready && req0_addr != ADDR_W'(ZERO_REG);
    ld1 = req1_valid && req1_ready && req1_addr != ADDR_W'(ZERO_REG);
    we3 = (g0 || g1) && !reset;
    wa3 = !we3 ? '0 : g0 ? s0.addr : s1.addr;
    wd3 = !we3 ? '0 : g0 ? s0.data : s1.data;
    pending = (v0 ? 32'd1 << s0.addr : 32'd0) | (v1 ? 32'd1 << s1.addr : 32'd0);
    busy = v0 || v1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= 1'b1;
      commit_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (tie) rr_ptr <= !rr_ptr;
      if (we3 && commit_cnt != '1) commit_cnt <= commit_cnt + CNT_W'(1);
      if (v0 && v1 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
endmodule
